// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if -- bundle of the serial-receiver signals.
//
// Signals:
//   RX_IN          serial line (idle high), already synchronised to CLK
//   Prescale       oversampling ratio (8, 16 or 32)
//   PAR_EN         1 = frame carries a parity bit
//   PAR_TYP        0 = even parity, 1 = odd parity
//   P_DATA         last good received byte
//   data_valid     one-cycle pulse, P_DATA holds a good frame
//   parity_error   one-cycle pulse, parity mismatch
//   framing_error  one-cycle pulse, stop bit sampled low
//
// Modports:
//   master  drives the line and configuration, observes the results
//   slave   the receiver itself
// ---------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      RX_IN;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      data_valid;
  logic                      parity_error;
  logic                      framing_error;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, parity_error, framing_error
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, parity_error, framing_error
  );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver.
//
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit,
// stop bit. Each bit is oversampled Prescale times; three mid-bit samples
// are majority-voted. A good frame updates P_DATA and pulses data_valid;
// parity / stop-bit faults pulse parity_error / framing_error instead.
//
// Ports:
//   CLK     oversampling clock (Prescale x baud)
//   RST     asynchronous active-low reset
//   rx_bus  uart_rx_if.slave: RX_IN, Prescale, PAR_EN, PAR_TYP in;
//           P_DATA, data_valid, parity_error, framing_error out
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic        CLK,
  input  logic        RST,
  uart_rx_if.slave    rx_bus
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = PRESCALE_WIDTH'(1);
  localparam logic [BIT_CNT_W-1:0]      BC_ONE   = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]      LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [1:0]                samp_q, samp_d;
  logic                      par_err_q, par_err_d;
  logic                      stp_err_q, stp_err_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
  logic                      data_valid_q, data_valid_d;
  logic                      parity_error_q, parity_error_d;
  logic                      framing_error_q, framing_error_d;

  logic [PRESCALE_WIDTH-1:0] mid;
  logic at_s0, at_s1, at_s2, at_wrap, bit_val, rx;

  assign rx      = rx_bus.RX_IN;
  assign mid     = prescale_q >> 1;
  assign at_s0   = (edge_cnt_q == mid - PS_ONE);
  assign at_s1   = (edge_cnt_q == mid);
  assign at_s2   = (edge_cnt_q == mid + PS_ONE);
  assign at_wrap = (edge_cnt_q == prescale_q - PS_ONE);
  // Third sample is the live line value, so the vote resolves at mid+1.
  assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx) | (samp_q[1] & rx);

  always_comb begin
    state_d         = state_q;
    edge_cnt_d      = edge_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    samp_d          = samp_q;
    par_err_d       = par_err_q;
    stp_err_d       = stp_err_q;
    prescale_d      = prescale_q;
    par_en_d        = par_en_q;
    par_typ_d       = par_typ_q;
    p_data_d        = p_data_q;
    data_valid_d    = 1'b0;
    parity_error_d  = 1'b0;
    framing_error_d = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = at_wrap ? '0 : edge_cnt_q + PS_ONE;
      if (at_s0) samp_d[0] = rx;
      if (at_s1) samp_d[1] = rx;
    end

    case (state_q)
      IDLE: begin
        prescale_d = rx_bus.Prescale;
        par_en_d   = rx_bus.PAR_EN;
        par_typ_d  = rx_bus.PAR_TYP;
        edge_cnt_d = '0;
        if (!rx) begin
          // This cycle is edge 0 of the start bit.
          state_d    = START;
          edge_cnt_d = PS_ONE;
          bit_cnt_d  = '0;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
        end
      end
      START: begin
        if (at_s2 && bit_val) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (at_wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_s2) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
        if (at_wrap) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_ONE;
          end
        end
      end
      PARITY: begin
        if (at_s2 && (bit_val != ((^shift_q) ^ par_typ_q))) par_err_d = 1'b1;
        if (at_wrap) state_d = STOP;
      end
      STOP: begin
        if (at_s2 && !bit_val) stp_err_d = 1'b1;
        if (at_wrap) begin
          // Outputs are registered here so the pulse coincides with DONE.
          state_d         = DONE;
          parity_error_d  = par_err_q;
          framing_error_d = stp_err_q;
          if (!par_err_q && !stp_err_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      DONE: begin
        if (!rx) begin
          // Back-to-back frame: this cycle is edge 0 of the next start bit.
          state_d    = START;
          edge_cnt_d = PS_ONE;
          bit_cnt_d  = '0;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
        end else begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q         <= IDLE;
      edge_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      samp_q          <= '0;
      par_err_q       <= 1'b0;
      stp_err_q       <= 1'b0;
      prescale_q      <= '0;
      par_en_q        <= 1'b0;
      par_typ_q       <= 1'b0;
      p_data_q        <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      edge_cnt_q      <= edge_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      samp_q          <= samp_d;
      par_err_q       <= par_err_d;
      stp_err_q       <= stp_err_d;
      prescale_q      <= prescale_d;
      par_en_q        <= par_en_d;
      par_typ_q       <= par_typ_d;
      p_data_q        <= p_data_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign rx_bus.P_DATA        = p_data_q;
  assign rx_bus.data_valid    = data_valid_q;
  assign rx_bus.parity_error  = parity_error_q;
  assign rx_bus.framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) u_if ();

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK    (clk),
    .RST    (rst_n),
    .rx_bus (u_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles of each output pulse.
  int dv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
  int dv_cyc = 0, err_cyc = 0;
  logic [7:0] dv_log[$];
  always @(negedge clk) begin
    if (u_if.data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
      dv_log.push_back(u_if.P_DATA);
    end
    if (u_if.parity_error) begin
      pe_cnt++;
      err_cyc = cyc;
    end
    if (u_if.framing_error) begin
      fe_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int ps_i = 8;
  int start_cyc = 0;

  // All stimulus tasks start and end at posedge+1.
  task automatic tick_bit(input logic v, input int flip_at);
    for (int e = 0; e < ps_i; e++) begin
      u_if.RX_IN = (e == flip_at) ? ~v : v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic sbit, input int noise_bit);
    start_cyc = cyc;
    tick_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) tick_bit(d[i], (i == noise_bit) ? (ps_i / 2 - 1) : -1);
    if (pe) tick_bit(pbit, -1);
    tick_bit(sbit, -1);
  endtask

  task automatic idle(input int n);
    u_if.RX_IN = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ps, input logic pe, input logic pt);
    ps_i          = ps;
    u_if.Prescale = 6'(ps);
    u_if.PAR_EN   = pe;
    u_if.PAR_TYP  = pt;
  endtask

  int dv0, pe0, fe0, n0;

  initial begin
    u_if.RX_IN = 1'b1;
    cfg(8, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_p_data", u_if.P_DATA, 0);
    chk("reset_data_valid", u_if.data_valid, 0);
    chk("reset_parity_error", u_if.parity_error, 0);
    chk("reset_framing_error", u_if.framing_error, 0);
    rst_n = 1'b1;
    idle(4);

    // Prescale 8, no parity, 0xA5
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    chk("a5_dv_pulses", dv_cnt - dv0, 1);
    chk("a5_data", dv_log[dv_log.size() - 1], 8'hA5);
    chk("a5_latency", dv_cyc - start_cyc, 80);
    chk("a5_p_data_hold", u_if.P_DATA, 8'hA5);
    chk("a5_no_perr", pe_cnt - pe0, 0);
    chk("a5_no_ferr", fe_cnt - fe0, 0);
    $display("txn a5: dv=%0d data=0x%0h lat=%0d", dv_cnt - dv0, u_if.P_DATA, dv_cyc - start_cyc);

    // Prescale 16, even parity, 0x3C good parity
    cfg(16, 1'b1, 1'b0);
    idle(2);
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
    idle(4);
    chk("3c_dv_pulses", dv_cnt - dv0, 1);
    chk("3c_data", u_if.P_DATA, 8'h3C);
    chk("3c_latency", dv_cyc - start_cyc, 176);
    chk("3c_no_perr", pe_cnt - pe0, 0);
    $display("txn 3c: dv=%0d data=0x%0h lat=%0d", dv_cnt - dv0, u_if.P_DATA, dv_cyc - start_cyc);

    // Same byte, wrong parity bit
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
    idle(4);
    chk("3c_bad_perr", pe_cnt - pe0, 1);
    chk("3c_bad_perr_latency", err_cyc - start_cyc, 176);
    chk("3c_bad_no_dv", dv_cnt - dv0, 0);
    chk("3c_bad_no_ferr", fe_cnt - fe0, 0);
    chk("3c_bad_p_data_kept", u_if.P_DATA, 8'h3C);
    $display("txn 3c-badpar: perr=%0d dv=%0d data=0x%0h", pe_cnt - pe0, dv_cnt - dv0, u_if.P_DATA);

    // Prescale 32, odd parity, 0x01, stop bit low
    cfg(32, 1'b1, 1'b1);
    idle(2);
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, -1);
    idle(4);
    chk("01_ferr", fe_cnt - fe0, 1);
    chk("01_ferr_latency", err_cyc - start_cyc, 352);
    chk("01_no_dv", dv_cnt - dv0, 0);
    chk("01_no_perr", pe_cnt - pe0, 0);
    $display("txn 01-frame: ferr=%0d perr=%0d dv=%0d", fe_cnt - fe0, pe_cnt - pe0, dv_cnt - dv0);

    // Glitch on the start bit, then a good frame
    cfg(8, 1'b0, 1'b0);
    idle(4);
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    u_if.RX_IN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    chk("glitch_no_dv", dv_cnt - dv0, 0);
    chk("glitch_no_err", (pe_cnt - pe0) + (fe_cnt - fe0), 0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    chk("55_dv_pulses", dv_cnt - dv0, 1);
    chk("55_data", u_if.P_DATA, 8'h55);
    $display("txn glitch+55: dv=%0d data=0x%0h", dv_cnt - dv0, u_if.P_DATA);

    // One-sample noise on data bit 3
    dv0 = dv_cnt;
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 3);
    idle(4);
    chk("f0_dv_pulses", dv_cnt - dv0, 1);
    chk("f0_data", u_if.P_DATA, 8'hF0);
    $display("txn noise f0: dv=%0d data=0x%0h", dv_cnt - dv0, u_if.P_DATA);

    // Back-to-back frames, reset in the middle of the third
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    n0 = dv_log.size();
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, -1);
    tick_bit(1'b0, -1);
    tick_bit(1'b0, -1);
    tick_bit(1'b1, -1);
    u_if.RX_IN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    u_if.RX_IN = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("b2b_pulses", dv_cnt - dv0, 2);
    chk("b2b_first", (dv_log.size() > n0) ? int'(dv_log[n0]) : -1, 8'h12);
    chk("b2b_second", (dv_log.size() > n0 + 1) ? int'(dv_log[n0 + 1]) : -1, 8'h34);
    chk("rst_p_data", u_if.P_DATA, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(200);
    chk("rst_no_more_dv", dv_cnt - dv0, 2);
    chk("rst_no_err", (pe_cnt - pe0) + (fe_cnt - fe0), 0);
    chk("post_rst_p_data", u_if.P_DATA, 0);
    chk("post_rst_outputs", {u_if.data_valid, u_if.parity_error, u_if.framing_error}, 0);
    $display("txn b2b+reset: dv=%0d data=0x%0h", dv_cnt - dv0, u_if.P_DATA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART link; mirror of the transmit path, which frames data as start bit, data, optional parity, stop bit.
- Oversamples RX_IN by a configurable prescale and takes a majority vote of three mid-bit samples.
- Deserialises 8 data bits, LSB first, and checks parity and stop bit.
- Presents a parallel byte with a one-cycle valid pulse to the system control logic.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of the Prescale input.

Ports:
- CLK  input  1  oversampling clock (Prescale × baud).
- RST  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line. Idle high. Already synchronised to CLK upstream.
- Prescale  input  PRESCALE_WIDTH  oversampling ratio. Legal values are 8, 16 and 32.
- PAR_EN  input  1  1 means a parity bit is present in the frame.
- PAR_TYP  input  1  0 selects even parity, 1 selects odd parity.
- P_DATA  output  DATA_WIDTH  received byte.
- data_valid  output  1  one-cycle pulse when P_DATA holds a good frame.
- parity_error  output  1  one-cycle pulse when a parity mismatch is detected.
- framing_error  output  1  one-cycle pulse when the stop bit is sampled 0.

Behaviour:
- Reset: RST=0 forces the FSM to IDLE and clears all counters. P_DATA=0, data_valid=0, parity_error=0, framing_error=0. Reset mid-frame abandons the frame with no output pulse.
- Configuration: Prescale, PAR_EN and PAR_TYP are sampled and held while in IDLE. Changes during a frame have no effect until the next frame.
- Counters:
  - edge_cnt runs 0..Prescale-1 and wraps to 0 at each bit boundary.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Start detection: the IDLE cycle in which RX_IN=0 is edge 0 of the start bit.
- Sampling:
  - Samples are taken at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - Bit value = majority of the three samples, resolved at edge_cnt = Prescale/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE -> START when RX_IN=0.
  - START: if the sampled bit is 1 (glitch), return to IDLE immediately at the sample point, with no output. Otherwise go to DATA at edge_cnt wrap.
  - DATA: shift the sampled bit into the MSB of the shift register (LSB-first line order). After bit DATA_WIDTH-1 wraps, go to PARITY if PAR_EN=1, else STOP.
  - PARITY: compute the expected bit as the XOR of the data bits, XOR PAR_TYP. A mismatch sets an internal par_err flag. Go to STOP at wrap.
  - STOP: a sampled 0 sets an internal stp_err flag. Go to DONE at edge_cnt = Prescale-1.
  - DONE lasts one cycle and drives the registered outputs:
    - No errors: P_DATA <= shift register and data_valid=1.
    - par_err set: parity_error=1.
    - stp_err set: framing_error=1.
    - With any error, data_valid=0 and P_DATA keeps its previous value. Both error pulses may assert together.
    - DONE -> START if RX_IN=0, treating this cycle as edge 0 of the next start bit. Otherwise DONE -> IDLE.
- Latency: the output pulse occurs exactly (1 + DATA_WIDTH + PAR_EN + 1) × Prescale cycles after the start edge-0 cycle.
- Output hold: P_DATA holds its value until the next good frame. All pulses are exactly one CLK wide.

Test Plan:
- Prescale=8, PAR_EN=0, send 0xA5 (line order 0,1,0,1,0,0,1,0,1,1) -> data_valid high for 1 cycle, 80 cycles after the start edge; P_DATA=0xA5; both error outputs stay 0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> data_valid pulses at cycle 176; P_DATA=0x3C. Repeat with parity bit 1 -> parity_error=1, data_valid=0, P_DATA stays 0x3C.
- Prescale=32, PAR_EN=1, PAR_TYP=1, send 0x01 with parity 0 and stop bit 0 -> framing_error=1 at cycle 352; data_valid=0; parity_error=0.
- Glitch: RX_IN low for 3 cycles at Prescale=8 -> returns to IDLE, no output pulses. Then send 0x55 -> P_DATA=0x55.
- Noise: one-cycle inversion on sample Prescale/2-1 of data bit 3 -> majority vote recovers the correct byte 0xF0.
- Back-to-back frames 0x12 then 0x34 with no idle gap; RST pulsed low mid-frame 3 -> two data_valid pulses with 0x12 and 0x34; frame 3 produces no pulse and all outputs read 0 after reset.
